// File: rtl/nic_poll_ctrl.sv
// nic_poll_ctrl: polls one NIC register port, moving producer flits out through a TX FIFO and NIC input flits into an RX FIFO
// Ports: clk/reset (sync, active-high); tx_data/tx_valid/tx_ready producer side;
// rx_data/rx_valid/rx_ready consumer side; nic_en/nic_wr/nic_addr/nic_din/nic_dout NIC register port;
// tx_sent_cnt/rx_recv_cnt wrapping flit counters; busy = FSM not idle.

module nic_poll_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_head  = r_mem[r_rd];
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

module nic_poll_ctrl #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int STATUS_BIT = 63,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              nic_en,
    output logic              nic_wr,
    output logic [1:0]        nic_addr,
    output logic [DATA_W-1:0] nic_din,
    input  logic [DATA_W-1:0] nic_dout,
    output logic [CNT_W-1:0]  tx_sent_cnt,
    output logic [CNT_W-1:0]  rx_recv_cnt,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, TX_POLL, TX_CHK, TX_WR, RX_POLL, RX_CHK, RX_RD, RX_CAP} state_t;
    state_t            r_state;
    state_t            w_next;
    logic              r_rr_tx;
    logic              w_tx_push;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic              w_tx_elig;
    logic              w_rx_elig;
    logic [DATA_W-1:0] w_tx_head;

    assign w_tx_push = tx_valid && tx_ready;
    assign tx_ready  = !w_tx_full;
    assign rx_valid  = !w_rx_empty;
    // a flit being pushed this cycle already counts, so an idle controller starts polling on the next edge
    assign w_tx_elig = !w_tx_empty || w_tx_push;
    // RX is only started with a free slot; nothing else pushes, so the capture cannot overflow
    assign w_rx_elig = !w_rx_full;
    assign busy      = r_state != IDLE;

    nic_poll_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx (
        .clk(clk), .reset(reset), .i_push(w_tx_push), .i_din(tx_data), .i_pop(r_state == TX_WR),
        .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
    );

    nic_poll_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx (
        .clk(clk), .reset(reset), .i_push(r_state == RX_CAP), .i_din(nic_dout), .i_pop(rx_ready),
        .o_head(rx_data), .o_full(w_rx_full), .o_empty(w_rx_empty)
    );

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = (w_tx_elig && (r_rr_tx || !w_rx_elig)) ? TX_POLL : w_rx_elig ? RX_POLL : IDLE;
            TX_POLL: w_next = TX_CHK;
            TX_CHK:  w_next = nic_dout[STATUS_BIT] ? IDLE : TX_WR;
            RX_POLL: w_next = RX_CHK;
            RX_CHK:  w_next = nic_dout[STATUS_BIT] ? RX_RD : IDLE;
            RX_RD:   w_next = RX_CAP;
            default: w_next = IDLE;
        endcase
    end

    // NIC port outputs are registered from the next state so they line up with r_state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rr_tx     <= 1'b1;
            nic_en      <= 1'b0;
            nic_wr      <= 1'b0;
            nic_addr    <= 2'b00;
            nic_din     <= '0;
            tx_sent_cnt <= '0;
            rx_recv_cnt <= '0;
        end else begin
            r_state  <= w_next;
            nic_en   <= w_next == TX_POLL || w_next == TX_WR || w_next == RX_POLL || w_next == RX_RD;
            nic_wr   <= w_next == TX_WR;
            nic_addr <= w_next == TX_POLL ? 2'b01 : w_next == RX_POLL ? 2'b11 : w_next == RX_RD ? 2'b10 : 2'b00;
            nic_din  <= w_next == TX_WR ? w_tx_head : '0;
            // whichever side is served now, the other side is favoured next time
            if (r_state == IDLE && (w_tx_elig || w_rx_elig))
                r_rr_tx <= w_next == RX_POLL;
            if (r_state == TX_WR)
                tx_sent_cnt <= tx_sent_cnt + CNT_W'(1);
            if (r_state == RX_CAP)
                rx_recv_cnt <= rx_recv_cnt + CNT_W'(1);
        end
    end
endmodule
